result_averager: RTL and testbench

RESULT_AVERAGER -- requirements
Module: result_averager

---
 rtl/result_averager.sv | 130 +++++++++++++
 tb/tb_result_averager.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/result_averager.sv
// rtl/result_averager.sv - windowed average / maximum of N = 2**LOG2_N unsigned samples
// Optional saturation counter is built when RESULT_AVERAGER_SAT_CNT_EN is defined.
module result_averager #(
  parameter int LOG2_N = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  output logic                in_ready,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0]          out_avg,
  output logic [7:0]          out_max
`ifdef RESULT_AVERAGER_SAT_CNT_EN
  ,
  output logic [LOG2_N:0]     out_sat_cnt
`endif
);

  localparam int N  = 1 << LOG2_N;
  localparam int SW = 8 + LOG2_N;
  localparam int CW = LOG2_N + 1;

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t        state;
  logic [SW-1:0] sum;
  logic [7:0]    max_val;
  logic [CW-1:0] count;

  logic [SW-1:0] sum_next;
  logic [SW-1:0] sample_ext;
  logic [7:0]    max_next;
  logic          last;

`ifdef RESULT_AVERAGER_SAT_CNT_EN
  logic [CW-1:0] sat_cnt;
  logic [CW-1:0] sat_next;
  logic [CW-1:0] sat_one;
`endif

  // While a result is held, a new sample may only enter in the cycle the result leaves.
  assign in_ready   = rst && (!out_valid || out_ready);

  assign sample_ext = {{LOG2_N{1'b0}}, in_data};
  assign sum_next   = sum + sample_ext;
  assign max_next   = (in_data > max_val) ? in_data : max_val;
  assign last       = (count == CW'(N - 1));

`ifdef RESULT_AVERAGER_SAT_CNT_EN
  assign sat_one  = {{(CW-1){1'b0}}, in_data[7]};
  assign sat_next = sat_cnt + sat_one;
`endif

  // Window accumulation, result capture and ACCUM/HOLD sequencing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ACCUM;
      out_valid <= 1'b0;
      sum       <= '0;
      max_val   <= '0;
      count     <= '0;
      out_avg   <= '0;
      out_max   <= '0;
`ifdef RESULT_AVERAGER_SAT_CNT_EN
      sat_cnt     <= '0;
      out_sat_cnt <= '0;
`endif
    end else begin
      case (state)
        ACCUM: begin
          if (flush) begin
            // A flush discards the partial window, including a sample offered this cycle.
            sum     <= '0;
            max_val <= '0;
            count   <= '0;
`ifdef RESULT_AVERAGER_SAT_CNT_EN
            sat_cnt <= '0;
`endif
          end else if (in_valid) begin
            if (last) begin
              out_avg   <= sum_next[SW-1:LOG2_N];
              out_max   <= max_next;
              state     <= HOLD;
              out_valid <= 1'b1;
              // Accumulators are emptied now; nothing accumulates while holding.
              sum       <= '0;
              max_val   <= '0;
              count     <= '0;
`ifdef RESULT_AVERAGER_SAT_CNT_EN
              out_sat_cnt <= sat_next;
              sat_cnt     <= '0;
`endif
            end else begin
              sum     <= sum_next;
              max_val <= max_next;
              count   <= count + CW'(1);
`ifdef RESULT_AVERAGER_SAT_CNT_EN
              sat_cnt <= sat_next;
`endif
            end
          end
        end
        HOLD: begin
          // flush is ignored here so the pending result survives.
          if (out_ready) begin
            state     <= ACCUM;
            out_valid <= 1'b0;
            if (in_valid) begin
              // Sample accepted alongside the transfer opens the next window.
              sum     <= sample_ext;
              max_val <= in_data;
              count   <= CW'(1);
`ifdef RESULT_AVERAGER_SAT_CNT_EN
              sat_cnt <= sat_one;
`endif
            end
          end
        end
        default: begin
          state     <= ACCUM;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_averager.sv
// tb/tb_result_averager.sv - self-checking bench for result_averager (LOG2_N=3)
module tb_result_averager;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_avg;
  logic [7:0] out_max;
`ifdef RESULT_AVERAGER_SAT_CNT_EN
  logic [3:0] out_sat_cnt;
`endif

  always #5 clk = ~clk;

  result_averager #(.LOG2_N(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_avg    (out_avg),
    .out_max    (out_max)
`ifdef RESULT_AVERAGER_SAT_CNT_EN
    ,
    .out_sat_cnt(out_sat_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: samples of the open window, and the last captured result.
  int  win[$];
  bit  pend;
  int  e_avg, e_max, e_sat;

  typedef struct {
    logic [7:0][7:0] s;
    int avg;
    int mx;
    int sat;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    win.delete();
    pend  = 1'b0;
    e_avg = 0;
    e_max = 0;
    e_sat = 0;
  endtask

  task automatic model_edge(input logic v, input logic [7:0] d, input logic o, input logic f);
    bit acc;
    int s, m, c;
    acc = v && (!pend || o);
    if (pend) begin
      if (o) begin
        pend = 1'b0;
        win.delete();
        if (acc) win.push_back(int'(d));
      end
    end else if (f) begin
      win.delete();
    end else if (acc) begin
      win.push_back(int'(d));
      if (win.size() == 8) begin
        s = 0; m = 0; c = 0;
        foreach (win[i]) begin
          s += win[i];
          if (win[i] > m) m = win[i];
          if (win[i] >= 128) c++;
        end
        e_avg = s / 8;
        e_max = m;
        e_sat = c;
        pend  = 1'b1;
        win.delete();
      end
    end
  endtask

  // One clock: drive at the falling edge, check just after, let the rising edge act.
  task automatic cyc(input logic v, input logic [7:0] d, input logic o, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = o;
    flush     = f;
    #1;
    chk("in_ready", int'(in_ready), int'(!pend || o));
    chk("out_valid", int'(out_valid), int'(pend));
    chk("out_avg", int'(out_avg), e_avg);
    chk("out_max", int'(out_max), e_max);
`ifdef RESULT_AVERAGER_SAT_CNT_EN
    chk("out_sat_cnt", int'(out_sat_cnt), e_sat);
`endif
    model_edge(v, d, o, f);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asynchronous reset pulse starting at a falling edge; outputs must clear at once.
  task automatic pulse_reset(input string nm);
    rst      = 1'b0;
    in_valid = 1'b0;
    flush    = 1'b0;
    #1;
    model_reset();
    chk({nm, "_in_ready"}, int'(in_ready), 0);
    chk({nm, "_out_valid"}, int'(out_valid), 0);
    chk({nm, "_out_avg"}, int'(out_avg), 0);
    chk({nm, "_out_max"}, int'(out_max), 0);
`ifdef RESULT_AVERAGER_SAT_CNT_EN
    chk({nm, "_out_sat_cnt"}, int'(out_sat_cnt), 0);
`endif
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check_result(input string nm, input int avg, input int mx, input int sat);
    #1;
    chk({nm, "_valid"}, int'(out_valid), 1);
    chk({nm, "_avg"}, int'(out_avg), avg);
    chk({nm, "_max"}, int'(out_max), mx);
`ifdef RESULT_AVERAGER_SAT_CNT_EN
    chk({nm, "_sat"}, int'(out_sat_cnt), sat);
`else
    if (sat < 0) chk({nm, "_sat"}, sat, 0);
`endif
  endtask

  initial begin
    vt[0].s = {8{8'd10}};
    vt[0].avg = 10;  vt[0].mx = 10;  vt[0].sat = 0;
    vt[1].s = {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    vt[1].avg = 3;   vt[1].mx = 7;   vt[1].sat = 0;
    vt[2].s = {8{8'd255}};
    vt[2].avg = 255; vt[2].mx = 255; vt[2].sat = 8;
    vt[3].s = {8'd255, 8'd0, 8'd127, 8'd128, 8'd129, 8'd50, 8'd200, 8'd100};
    vt[3].avg = 123; vt[3].mx = 255; vt[3].sat = 4;
    vt[4].s = {8'd6, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1};
    vt[4].avg = 0;   vt[4].mx = 6;   vt[4].sat = 0;

    rst = 1'b0; in_valid = 1'b0; in_data = 8'd0; flush = 1'b0; out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    pulse_reset("reset");

    // Table windows, downstream always ready; result must appear one cycle after sample 8.
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 8; i++) cyc(1'b1, vt[k].s[i], 1'b1, 1'b0);
      check_result($sformatf("vec%0d", k), vt[k].avg, vt[k].mx, vt[k].sat);
      cyc(1'b0, 8'd0, 1'b1, 1'b0);
    end

    // Stall for 5 cycles with an offered sample, flush ignored while holding, then
    // transfer together with sample 50 which must open the next window.
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(30 + i), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'd99, 1'b0, (i == 2));
    check_result("stall", 33, 37, 0);
    cyc(1'b1, 8'd50, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'd50, 1'b1, 1'b0);
    check_result("xfer_start", 50, 50, 0);
    cyc(1'b0, 8'd0, 1'b1, 1'b0);

    // Partial window flushed; the sample offered with flush is discarded.
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'd200, 1'b1, 1'b0);
    cyc(1'b1, 8'd200, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'd20, 1'b1, 1'b0);
    check_result("flush", 20, 20, 0);
    cyc(1'b0, 8'd0, 1'b1, 1'b0);

    // Reset mid-window, then reset while a result is held.
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'd180, 1'b1, 1'b0);
    pulse_reset("rst_mid");
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'd7, 1'b1, 1'b0);
    check_result("after_rst", 7, 7, 0);
    pulse_reset("rst_hold");

    // Back-to-back windows with both sides ready: no bubble between results.
    for (int i = 0; i < 24; i++) cyc(1'b1, 8'(i * 9), 1'b1, 1'b0);

    // Randomised traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(599) == 0) begin
        pulse_reset("rand_rst");
      end else begin
        cyc($urandom_range(3) != 0,
            ($urandom_range(1) != 0) ? 8'($urandom_range(255, 128)) : 8'($urandom_range(127, 0)),
            $urandom_range(3) != 0,
            $urandom_range(15) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
